coproc_bus_master: RTL and testbench
====================================

// Module: coproc_bus_master
// PURPOSE
//  CPU-side initiator for the 32-bit coprocessor bus. Takes one request from the core
//  (dev addr + 24-bit operand), drives the GET command word, waits for the matching
//  POST word {1,dev,5'b0,data}, clears the device's result register and returns the
//  data (or a timeout) to the core. One transaction in flight at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  1024   max WAIT cycles before giving up (>=2)
//  IDLE_DEV        2'b11  reserved bus address; no coprocessor is ever configured on it
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   core request strobe
//  req_ready    out  1   1 only in IDLE; transfer when req_valid & req_ready
//  req_dev      in   2   target device address
//  req_data     in   24  operand
//  bus_out      out  32  word driven to the coprocessors' bus input
//  bus_in       in   32  OR of the coprocessors' result registers
//  rsp_valid    out  1   one-cycle response strobe
//  rsp_timeout  out  1   qualifies rsp_valid: no POST seen or request to IDLE_DEV
//  rsp_dev      out  2   device of the completed request
//  rsp_data     out  24  result (0 on timeout)
//  busy         out  1   1 in every state except IDLE
// BEHAVIOUR
//  Clock is clk; reset rst is synchronous, active-high. All outputs are registered
//  except req_ready = (state==IDLE).
//  Word format: [31] valid, [30:29] resp dev, [28:24] 0 (POST); for commands:
//  [31:30] dev, [29:24] cmd (6'h00 = GET/issue, 6'h3F = CLEAR), [23:0] payload.
//  IDLE_WORD = {IDLE_DEV, 6'h3F, 24'h0}; driven whenever no command is due.
//  Reset: state IDLE, bus_out=IDLE_WORD, rsp_valid=0, rsp_timeout=0, rsp_dev=0,
//  rsp_data=0, busy=0, timeout counter=0. Reset mid-transaction abandons it silently;
//  a stale result left in a coprocessor is removed by the next PRECLEAR.
//  FSM (one cycle per state unless noted):
//   IDLE: on handshake latch dev/data. dev==IDLE_DEV -> DONE with timeout=1, no bus
//         activity; else -> PRECLEAR.
//   PRECLEAR: bus_out={dev,6'h3F,24'h0} -> ISSUE. Guarantees result reg is clear.
//   ISSUE: bus_out={dev,6'h00,data} for exactly one cycle (target pulses start
//          every cycle it is addressed) -> WAIT; counter cleared.
//   WAIT (1..TIMEOUT_CYCLES cycles): bus_out=IDLE_WORD. Match = bus_in[31] &
//         bus_in[30:29]==dev & bus_in[28:24]==0 -> capture bus_in[23:0], -> CLEAR.
//         Else counter++; at counter==TIMEOUT_CYCLES-1 without match -> CLEAR,
//         timeout=1, data=0. Match on that same cycle wins over timeout.
//   CLEAR: bus_out={dev,6'h3F,24'h0}; rsp_valid=1 with rsp_* this cycle -> IDLE.
//   DONE (IDLE_DEV path only): rsp_valid=1, rsp_timeout=1 -> IDLE.
//  Latency: handshake edge -> PRECLEAR, ISSUE, first WAIT cycle; if POST visible in
//  first WAIT cycle, rsp_valid in following cycle: 4 cycles after handshake; min
//  back-to-back request period 5 cycles. req_valid outside IDLE is ignored (held).
//  Non-matching POST words (other dev) are ignored; never cleared by this block.
// STRUCTURE
//  Shared include coproc_bus_defs.vh: CMD_GET/CMD_CLEAR, field bit positions,
//  IDLE_WORD builder macro, state encodings (used also by coprocessor-side blocks).
//  Single module; timeout counter width $clog2(TIMEOUT_CYCLES), inline. No sub-module.
// TESTING
//  1 req dev=1 data=24'h00ABCD, model posts 24'h123456 at first WAIT cycle -> words
//    {1,6'h3F,0},{1,6'h00,ABCD}; rsp_valid 4 cyc after handshake, data=123456, to=0.
//  2 POST for dev=2 while waiting on dev=1, then dev=1 POST after 10 cyc -> dev2
//    ignored, rsp_data from dev1, CLEAR addresses dev1 only.
//  3 TIMEOUT_CYCLES=8, no POST -> rsp_valid after 8 WAIT cycles, timeout=1, data=0.
//  4 req_dev=IDLE_DEV -> bus_out stays IDLE_WORD, rsp_valid+timeout 1 cycle later.
//  5 rst asserted in WAIT -> next cycle IDLE, bus_out=IDLE_WORD, no rsp_valid; next
//    request's PRECLEAR removes stale result, returns fresh data.
//  6 req_valid held high continuously -> one handshake per 5 cycles, ready=0 else.

Source files
------------

// File: rtl/coproc_bus_master_pkg.sv
// rtl/coproc_bus_master_pkg.sv - coprocessor bus word layout, commands and master FSM states
package coproc_bus_master_pkg;

  localparam int DEV_W  = 2;
  localparam int DATA_W = 24;
  localparam int WORD_W = 32;
  localparam int CMD_W  = 6;

  localparam logic [CMD_W-1:0] CMD_GET   = 6'h00;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 6'h3F;

  // POST word fields: [31] valid, [30:29] responding dev, [28:24] zero, [23:0] result
  localparam int POST_VALID_BIT = 31;
  localparam int POST_DEV_HI    = 30;
  localparam int POST_DEV_LO    = 29;
  localparam int POST_PAD_HI    = 28;
  localparam int POST_PAD_LO    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECLEAR,
    ST_ISSUE,
    ST_WAIT,
    ST_CLEAR,
    ST_DONE
  } state_t;

  function automatic logic [WORD_W-1:0] cmd_word(
    input logic [DEV_W-1:0]  dev,
    input logic [CMD_W-1:0]  cmd,
    input logic [DATA_W-1:0] payload
  );
    return {dev, cmd, payload};
  endfunction

  function automatic logic post_match(
    input logic [WORD_W-1:0] word,
    input logic [DEV_W-1:0]  dev
  );
    return word[POST_VALID_BIT]
        && (word[POST_DEV_HI:POST_DEV_LO] == dev)
        && (word[POST_PAD_HI:POST_PAD_LO] == 5'd0);
  endfunction

endpackage

// File: rtl/coproc_bus_master_if.sv
// rtl/coproc_bus_master_if.sv - core request/response handshake and coprocessor bus wires
interface coproc_bus_master_if;
  import coproc_bus_master_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DEV_W-1:0]  req_dev;
  logic [DATA_W-1:0] req_data;

  logic [WORD_W-1:0] bus_out;
  logic [WORD_W-1:0] bus_in;

  logic              rsp_valid;
  logic              rsp_timeout;
  logic [DEV_W-1:0]  rsp_dev;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    input  req_valid, req_dev, req_data, bus_in,
    output req_ready, bus_out, rsp_valid, rsp_timeout, rsp_dev, rsp_data, busy
  );

  modport slave (
    output req_valid, req_dev, req_data, bus_in,
    input  req_ready, bus_out, rsp_valid, rsp_timeout, rsp_dev, rsp_data, busy
  );

endinterface

// File: rtl/coproc_bus_master.sv
// rtl/coproc_bus_master.sv - single-outstanding GET/POST initiator on the coprocessor bus
module coproc_bus_master
  import coproc_bus_master_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [1:0] IDLE_DEV       = 2'b11
) (
  input logic                 clk,
  input logic                 rst,
  coproc_bus_master_if.master cp
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WORD_W-1:0] IDLE_WORD = {IDLE_DEV, CMD_CLEAR, 24'h0};

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DEV_W-1:0]  dev_q;
  logic [DATA_W-1:0] data_q;
  logic [WORD_W-1:0] bus_word;
  logic              rsp_valid_q;
  logic              rsp_timeout_q;
  logic [DEV_W-1:0]  rsp_dev_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              busy_q;
  logic              hit;

  assign hit = post_match(cp.bus_in, dev_q);

  // bus_out is registered, so each branch loads the word of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      dev_q         <= '0;
      data_q        <= '0;
      bus_word      <= IDLE_WORD;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_dev_q     <= '0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cp.req_valid) begin
            dev_q  <= cp.req_dev;
            data_q <= cp.req_data;
            busy_q <= 1'b1;
            if (cp.req_dev == IDLE_DEV) begin
              state         <= ST_DONE;
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b1;
              rsp_dev_q     <= cp.req_dev;
              rsp_data_q    <= '0;
            end else begin
              state    <= ST_PRECLEAR;
              bus_word <= cmd_word(cp.req_dev, CMD_CLEAR, 24'h0);
            end
          end
        end
        ST_PRECLEAR: begin
          state    <= ST_ISSUE;
          bus_word <= cmd_word(dev_q, CMD_GET, data_q);
        end
        ST_ISSUE: begin
          state    <= ST_WAIT;
          bus_word <= IDLE_WORD;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          // a POST arriving on the final wait cycle still counts as a hit
          if (hit || (wait_cnt == CNT_LAST)) begin
            state         <= ST_CLEAR;
            bus_word      <= cmd_word(dev_q, CMD_CLEAR, 24'h0);
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= !hit;
            rsp_dev_q     <= dev_q;
            rsp_data_q    <= hit ? cp.bus_in[DATA_W-1:0] : '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_CLEAR: begin
          state    <= ST_IDLE;
          bus_word <= IDLE_WORD;
          busy_q   <= 1'b0;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          bus_word <= IDLE_WORD;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cp.req_ready   = (state == ST_IDLE);
  assign cp.bus_out     = bus_word;
  assign cp.rsp_valid   = rsp_valid_q;
  assign cp.rsp_timeout = rsp_timeout_q;
  assign cp.rsp_dev     = rsp_dev_q;
  assign cp.rsp_data    = rsp_data_q;
  assign cp.busy        = busy_q;

endmodule

// File: tb/tb_coproc_bus_master.sv
// tb/tb_coproc_bus_master.sv - scoreboard bench with coprocessor models and random requests
module tb_coproc_bus_master;
  import coproc_bus_master_pkg::*;

  localparam int          T        = 8;
  localparam logic [1:0]  IDEV     = 2'b11;
  localparam logic [31:0] IDLE_W   = 32'hFF00_0000;

  typedef struct {
    logic        to;
    logic [1:0]  dev;
    logic [23:0] data;
    int          at;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coproc_bus_master_if cp();

  coproc_bus_master #(.TIMEOUT_CYCLES(T), .IDLE_DEV(IDEV)) dut (
    .clk(clk),
    .rst(rst),
    .cp (cp.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rsp_t        rsp_q[$];
  logic [31:0] bus_q[$];

  logic [31:0] res[3];
  bit          pend[3];
  int          cnt_d[3];
  logic [23:0] op_seen[3];
  int          dev_lat[3];
  logic [31:0] noise;
  logic [1:0]  cur_dev;
  bit          noise_en;

  assign cp.bus_in = res[0] | res[1] | res[2] | noise;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [23:0] dev_fn(input logic [1:0] k, input logic [23:0] op);
    return (op ^ 24'h5A3C96) + {22'd0, k} + 24'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Coprocessors: a GET arms a countdown of dev_lat cycles, CLEAR wipes the result
  always @(negedge clk) begin : coprocs
    logic [31:0] w;
    logic [1:0]  nd;
    w = cp.bus_out;
    for (int k = 0; k < 3; k++) begin
      if (w[31:30] == k[1:0] && w[29:24] == 6'h00) begin
        pend[k]    = 1'b1;
        cnt_d[k]   = dev_lat[k];
        op_seen[k] = w[23:0];
      end else if (w[31:30] == k[1:0] && w[29:24] == 6'h3F) begin
        pend[k] = 1'b0;
        res[k]  = 32'h0;
      end else if (pend[k]) begin
        if (cnt_d[k] == 0) begin
          res[k]  = {1'b1, k[1:0], 5'b0, dev_fn(k[1:0], op_seen[k])};
          pend[k] = 1'b0;
        end else begin
          cnt_d[k]--;
        end
      end
    end
    noise = 32'h0;
    if (noise_en && (res[0] | res[1] | res[2]) == 32'h0 && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 0) begin
        nd    = cur_dev ^ 2'($urandom_range(1, 3));
        noise = {1'b1, nd, 5'b0, 24'($urandom)};
      end else begin
        noise = {1'b1, cur_dev, 5'($urandom_range(1, 31)), 24'($urandom)};
      end
    end
  end

  always @(negedge clk) begin : monitor
    rsp_t        e;
    logic [31:0] wexp;
    if (!rst) begin
      if (cp.rsp_valid) begin
        if (rsp_q.size() == 0) fail("unexpected_rsp");
        else begin
          e = rsp_q.pop_front();
          chk("rsp_timeout", 32'(cp.rsp_timeout), 32'(e.to));
          chk("rsp_dev", 32'(cp.rsp_dev), 32'(e.dev));
          chk("rsp_data", 32'(cp.rsp_data), 32'(e.data));
          chk("rsp_cycle", 32'(cyc), 32'(e.at));
        end
      end
      if (cp.bus_out !== IDLE_W) begin
        if (bus_q.size() == 0) begin
          fail("unexpected_bus_word");
          $display("  word=%h", cp.bus_out);
        end else begin
          wexp = bus_q.pop_front();
          chk("bus_word", cp.bus_out, wexp);
        end
      end
    end
  end

  // hs is the cycle number of the first cycle after the handshake edge
  task automatic push_exp(input logic [1:0] dev, input logic [23:0] data,
                          input int lat, input int hs, input bit abort);
    rsp_t e;
    if (dev == IDEV) begin
      e = '{to: 1'b1, dev: dev, data: 24'h0, at: hs};
      rsp_q.push_back(e);
      return;
    end
    bus_q.push_back({dev, 6'h3F, 24'h0});
    bus_q.push_back({dev, 6'h00, data});
    if (abort) return;
    bus_q.push_back({dev, 6'h3F, 24'h0});
    if (lat <= T - 1) e = '{to: 1'b0, dev: dev, data: dev_fn(dev, data), at: hs + 3 + lat};
    else              e = '{to: 1'b1, dev: dev, data: 24'h0, at: hs + 2 + T};
    rsp_q.push_back(e);
  endtask

  task automatic do_req(input logic [1:0] dev, input logic [23:0] data,
                        input int lat, input bit abort);
    int g;
    g = 0;
    @(negedge clk);
    while (!cp.req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      fail("ready_wait_timeout");
      return;
    end
    if (dev != IDEV) dev_lat[dev] = lat;
    cur_dev      = dev;
    cp.req_valid = 1'b1;
    cp.req_dev   = dev;
    cp.req_data  = data;
    push_exp(dev, data, lat, cyc + 1, abort);
    @(negedge clk);
    cp.req_valid = 1'b0;
    cp.req_dev   = 2'($urandom);
    cp.req_data  = 24'($urandom);
  endtask

  initial begin
    int          last_hs;
    int          n;
    int          g;
    logic [1:0]  d;
    logic [23:0] x;

    for (int k = 0; k < 3; k++) begin
      res[k] = 32'h0; pend[k] = 1'b0; cnt_d[k] = 0; dev_lat[k] = 0; op_seen[k] = 24'h0;
    end
    noise = 32'h0; noise_en = 1'b0; cur_dev = 2'd0;
    cp.req_valid = 1'b0; cp.req_dev = 2'd0; cp.req_data = 24'h0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bus_out", cp.bus_out, IDLE_W);
    chk("reset_rsp_valid", 32'(cp.rsp_valid), 32'd0);
    chk("reset_rsp_timeout", 32'(cp.rsp_timeout), 32'd0);
    chk("reset_rsp_dev", 32'(cp.rsp_dev), 32'd0);
    chk("reset_rsp_data", 32'(cp.rsp_data), 32'd0);
    chk("reset_busy", 32'(cp.busy), 32'd0);
    chk("reset_ready", 32'(cp.req_ready), 32'd1);
    rst = 1'b0;
    noise_en = 1'b1;

    do_req(2'd1, 24'h00ABCD, 0, 1'b0);
    do_req(2'd1, 24'h13579B, 6, 1'b0);
    do_req(2'd2, 24'h2468AC, 100, 1'b0);
    do_req(2'd0, 24'h0F0F0F, T - 1, 1'b0);
    do_req(2'd2, 24'h777777, T, 1'b0);
    do_req(IDEV, 24'hFFFFFF, 0, 1'b0);

    do_req(2'd0, 24'hC0FFEE, T + 5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_bus_out", cp.bus_out, IDLE_W);
    chk("rst_wait_busy", 32'(cp.busy), 32'd0);
    chk("rst_wait_ready", 32'(cp.req_ready), 32'd1);
    chk("rst_wait_rsp_valid", 32'(cp.rsp_valid), 32'd0);
    repeat (25) @(negedge clk);
    do_req(2'd0, 24'h0BEEF0, 2, 1'b0);

    cp.req_valid = 1'b1;
    last_hs = 0; n = 0; g = 0;
    while (n < 6 && g < 200) begin
      @(negedge clk);
      g++;
      if (n > 0) begin
        chk("ready_b2b", 32'(cp.req_ready), 32'(cyc >= last_hs + 4));
        chk("busy_b2b", 32'(cp.busy), 32'(cyc < last_hs + 4));
      end
      if (cp.req_ready) begin
        d = 2'($urandom_range(0, 2));
        x = 24'($urandom);
        dev_lat[d]  = 0;
        cur_dev     = d;
        cp.req_dev  = d;
        cp.req_data = x;
        push_exp(d, x, 0, cyc + 1, 1'b0);
        if (n > 0) chk("b2b_period", 32'(cyc + 1 - last_hs), 32'd5);
        last_hs = cyc + 1;
        n++;
      end
    end
    if (g >= 200) fail("b2b_timeout");
    @(negedge clk);
    cp.req_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      do_req(2'($urandom_range(0, 3)), 24'($urandom), $urandom_range(0, T + 2), 1'b0);
    end

    g = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
